// File: rtl/data_memory_block.sv
// rtl/data_memory_block.sv - DM pipeline stage: 256x8 data RAM plus registered EX/memory result mux.
// Optional MEM_CLEAR_ON_RESET_EN: reset also zeroes every RAM word.
module data_memory_block #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 1 << ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] ans_ex,
  input  logic [DATA_W-1:0] DM_data,
  input  logic              mem_rw_ex,
  input  logic              mem_en_ex,
  input  logic              mem_mux_sel_dm,
  output logic [DATA_W-1:0] ans_dm
);

  logic [DATA_W-1:0] ex_out;
  logic [DATA_W-1:0] dm_out;
  logic [DATA_W-1:0] mem [0:DEPTH-1];
  logic [ADDR_W-1:0] addr;
  logic              wr_en;
  logic              rd_en;

  // Upper ans_ex bits are ignored so addresses wrap when ADDR_W < DATA_W.
  assign addr  = ans_ex[ADDR_W-1:0];
  assign wr_en = mem_en_ex & mem_rw_ex;
  assign rd_en = mem_en_ex & ~mem_rw_ex;

  always_ff @(posedge clk) begin
    if (reset) begin
      ex_out <= '0;
      dm_out <= '0;
    end else begin
      ex_out <= ans_ex;
      if (rd_en) begin
        dm_out <= mem[addr];
      end
    end
  end

`ifdef MEM_CLEAR_ON_RESET_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (wr_en) begin
      mem[addr] <= DM_data;
    end
  end
`else
  // No reset on the array so it can map onto block RAM.
  always_ff @(posedge clk) begin
    if (!reset && wr_en) begin
      mem[addr] <= DM_data;
    end
  end
`endif

  assign ans_dm = mem_mux_sel_dm ? dm_out : ex_out;

endmodule

// File: tb/tb_data_memory_block.sv
// tb/tb_data_memory_block.sv - directed plus randomized checks of data_memory_block against a RAM/result model.
module tb_data_memory_block;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] ans_ex;
  logic [7:0] DM_data;
  logic       mem_rw_ex;
  logic       mem_en_ex;
  logic       mem_mux_sel_dm;
  logic [7:0] ans_dm;

  int checks = 0;
  int errors = 0;

  logic [7:0] model_mem [256];
  bit         written   [256];
  logic [7:0] m_ex;
  logic [7:0] m_dm;
  logic [7:0] exp_after_reset_read;

  always #5 clk = ~clk;

  data_memory_block dut (
    .clk           (clk),
    .reset         (reset),
    .ans_ex        (ans_ex),
    .DM_data       (DM_data),
    .mem_rw_ex     (mem_rw_ex),
    .mem_en_ex     (mem_en_ex),
    .mem_mux_sel_dm(mem_mux_sel_dm),
    .ans_dm        (ans_dm)
  );

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  initial begin
    // 1: reset held for two edges, both select values
    reset = 1'b1; ans_ex = 8'h03; DM_data = 8'h00;
    mem_rw_ex = 1'b0; mem_en_ex = 1'b0; mem_mux_sel_dm = 1'b0;
    step;
    check("reset_sel0", ans_dm, 8'h00);
    mem_mux_sel_dm = 1'b1; #1;
    check("reset_sel1", ans_dm, 8'h00);
    step;
    check("reset_edge2", ans_dm, 8'h00);

    // 2: EX path latency
    reset = 1'b0; ans_ex = 8'h03; mem_en_ex = 1'b0; mem_mux_sel_dm = 1'b0;
    step;
    check("ex_path_03", ans_dm, 8'h03);
    ans_ex = 8'h5A;
    step;
    check("ex_path_5a", ans_dm, 8'h5A);

    // 3: write then read back
    ans_ex = 8'h03; DM_data = 8'hFF; mem_en_ex = 1'b1; mem_rw_ex = 1'b1; mem_mux_sel_dm = 1'b1;
    step;
    check("write_dm_holds", ans_dm, 8'h00);
    mem_rw_ex = 1'b0;
    step;
    check("read_03", ans_dm, 8'hFF);
    ans_ex = 8'h04; DM_data = 8'h00; mem_rw_ex = 1'b1;
    step;
    check("write_04_dm_holds", ans_dm, 8'hFF);
    mem_rw_ex = 1'b0;
    step;
    check("read_04", ans_dm, 8'h00);

    // 4: disabled access must not write
    ans_ex = 8'h03; DM_data = 8'hAA; mem_en_ex = 1'b0; mem_rw_ex = 1'b1;
    step;
    check("disabled_dm_holds", ans_dm, 8'h00);
    mem_en_ex = 1'b1; mem_rw_ex = 1'b0;
    step;
    check("disabled_no_write", ans_dm, 8'hFF);

    // 5: select is combinational
    mem_en_ex = 1'b0;
    mem_mux_sel_dm = 1'b0; #1;
    check("comb_sel0", ans_dm, 8'h03);
    mem_mux_sel_dm = 1'b1; #1;
    check("comb_sel1", ans_dm, 8'hFF);

    // 6: reset during a write suppresses it
    reset = 1'b1; mem_en_ex = 1'b1; mem_rw_ex = 1'b1; ans_ex = 8'h03; DM_data = 8'h11;
    step;
    check("reset_mid_write_sel1", ans_dm, 8'h00);
    mem_mux_sel_dm = 1'b0; #1;
    check("reset_mid_write_sel0", ans_dm, 8'h00);
    reset = 1'b0; mem_rw_ex = 1'b0; mem_mux_sel_dm = 1'b1;
`ifdef MEM_CLEAR_ON_RESET_EN
    exp_after_reset_read = 8'h00;
`else
    exp_after_reset_read = 8'hFF;
`endif
    step;
    check("read_after_reset", ans_dm, exp_after_reset_read);

    // Model state matching the directed sequence so far.
    for (int i = 0; i < 256; i++) begin
      model_mem[i] = 8'h00;
      written[i]   = 1'b0;
`ifdef MEM_CLEAR_ON_RESET_EN
      written[i]   = 1'b1;
`endif
    end
    model_mem[3] = exp_after_reset_read; written[3] = 1'b1;
`ifndef MEM_CLEAR_ON_RESET_EN
    model_mem[4] = 8'h00; written[4] = 1'b1;
`endif
    m_ex = 8'h03;
    m_dm = exp_after_reset_read;

    // Randomized traffic against the model.
    for (int n = 0; n < 400; n++) begin
      reset          = ($urandom_range(0, 99) < 3);
      ans_ex         = 8'($urandom);
      DM_data        = 8'($urandom);
      mem_en_ex      = 1'($urandom);
      mem_rw_ex      = 1'($urandom);
      mem_mux_sel_dm = 1'($urandom);
      if (mem_en_ex && !mem_rw_ex && !written[ans_ex]) mem_rw_ex = 1'b1;

      if (reset) begin
        m_ex = 8'h00;
        m_dm = 8'h00;
`ifdef MEM_CLEAR_ON_RESET_EN
        for (int i = 0; i < 256; i++) model_mem[i] = 8'h00;
`endif
      end else begin
        m_ex = ans_ex;
        if (mem_en_ex && mem_rw_ex) begin
          model_mem[ans_ex] = DM_data;
          written[ans_ex]   = 1'b1;
        end else if (mem_en_ex) begin
          m_dm = model_mem[ans_ex];
        end
      end

      step;
      check("rand_edge", ans_dm, mem_mux_sel_dm ? m_dm : m_ex);
      mem_mux_sel_dm = ~mem_mux_sel_dm; #1;
      check("rand_flip", ans_dm, mem_mux_sel_dm ? m_dm : m_ex);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/data_memory_block.md
Name: data_memory_block

Overview:
Data-memory (DM) pipeline stage of the 8-bit NTP microprocessor, between the execute (EX) stage and write-back.
- Takes the EX result ans_ex, which is either an ALU result or a memory address.
- Optionally reads or writes an internal 256x8 data RAM at that address.
- Forwards either the registered ALU result or the registered memory read data to the next stage as ans_dm.

Parameters:
- DATA_W, 8, data word width (ans_ex, DM_data, ans_dm, RAM word).
- ADDR_W, 8, RAM address width; address = ans_ex[ADDR_W-1:0].
- DEPTH, 1<<ADDR_W, number of RAM words (256 at default).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- ans_ex  input  DATA_W  EX-stage result; also the RAM address.
- DM_data  input  DATA_W  store data written to RAM.
- mem_rw_ex  input  1  1 = write, 0 = read (qualified by mem_en_ex).
- mem_en_ex  input  1  memory access enable.
- mem_mux_sel_dm  input  1  output select: 0 = EX result path, 1 = memory data path.
- ans_dm  output  DATA_W  DM-stage result to write-back.

Behaviour:
- Internal state:
  - ex_out reg (DATA_W)
  - dm_out reg (DATA_W)
  - RAM mem[0:DEPTH-1]
- Reset (reset=1 at rising edge):
  - ex_out <= 0, dm_out <= 0; reset has priority over every other action.
  - No RAM write occurs in a reset cycle.
  - RAM contents are preserved (unless MEM_CLEAR_ON_RESET_EN; see Optional Feature).
- Normal edge (reset=0):
  - ex_out <= ans_ex, unconditionally, every cycle.
  - mem_en_ex=1, mem_rw_ex=1: mem[ans_ex] <= DM_data; dm_out holds.
  - mem_en_ex=1, mem_rw_ex=0: dm_out <= mem[ans_ex], using pre-edge contents.
  - mem_en_ex=0: no RAM access; dm_out holds; mem_rw_ex is ignored.
- Output: ans_dm = mem_mux_sel_dm ? dm_out : ex_out.
  - The mux is combinational on mem_mux_sel_dm, so a select change shows on ans_dm immediately, without waiting for a clock edge.
- Latency:
  - One clock from ans_ex to ans_dm on the EX path.
  - One clock from read request to ans_dm on the memory path.
  - A write followed by a read of the same address on the next cycle returns the new data.
- Address wrap: only ans_ex[ADDR_W-1:0] is used; upper bits are ignored when ADDR_W < DATA_W.
- Uninitialised RAM reads return X in simulation unless MEM_CLEAR_ON_RESET_EN is defined.
- Reset asserted mid-operation:
  - Any write pending in that cycle is suppressed.
  - ans_dm = 0 after the edge, regardless of mem_mux_sel_dm.
- No handshake; the enables are single-cycle, level-sensitive qualifiers.

Optional Feature:
- Macro: MEM_CLEAR_ON_RESET_EN.
- Defined:
  - Every reset edge also clears all DEPTH RAM words to 0, in the same cycle.
  - After reset, any read returns 0 until the location is written.
- Undefined:
  - RAM is not touched by reset and keeps its contents across reset.
  - Storage may map to block RAM.

Test Plan:
1. Reset: reset=1 for 2 edges, ans_ex=03, mem_mux_sel_dm=0 or 1 -> ans_dm=00 throughout.
2. EX path: reset=0, ans_ex=03, mem_en_ex=0, sel=0 -> ans_dm=03 after the next rising edge. Change ans_ex=5A -> ans_dm=5A one edge later.
3. Write-then-read: ans_ex=03, DM_data=FF, en=1, rw=1 for one edge, dm_out unchanged. Then rw=0, sel=1 -> ans_dm=FF after the next edge. A second write of 00 to address 04, read back from 04 -> 00.
4. Disabled access: en=0, rw=1, DM_data=AA, ans_ex=03 -> mem[03] stays FF; subsequent read gives ans_dm=FF.
5. Combinational select: dm_out=FF, ex_out=03; toggle sel 1->0 between edges -> ans_dm changes FF->03 with no clock.
6. Reset mid-write: reset=1 with en=1, rw=1, ans_ex=03, DM_data=11 -> ans_dm=00; after release, a read of 03 returns FF (write suppressed). With MEM_CLEAR_ON_RESET_EN defined, it returns 00.
